// File: rtl/axi_wr_queue.sv
// Posted write buffer: queues line/single writes and issues them one at a time as AXI AW/W/B transactions.
// Latency: enqueue to awvalid/wvalid is 2 cycles when idle; one transaction is outstanding at a time.
// Backpressure: wr_rdy drops when all DEPTH entries are occupied; AW/W outputs hold while awready/wready are low.
module axi_wr_queue #(
   parameter int D_BYTES_PER_LINE = 16,
   parameter int DEPTH = 4,
   parameter logic [3:0] AXI_ID = 4'd0,
   localparam int D_WORDS_PER_LINE = D_BYTES_PER_LINE / 4,
   localparam int D_LINE_WIDTH = 32 * D_WORDS_PER_LINE
) (
   input  logic                    clk,
   input  logic                    reset,
   // enqueue side
   input  logic                    wr_req,
   output logic                    wr_rdy,
   input  logic                    burst,
   input  logic [D_LINE_WIDTH-1:0] data,
   input  logic [31:0]             addr,
   input  logic [1:0]              size,
   input  logic [3:0]              strb,
   // read-side coordination
   input  logic                    read_unfinish,
   input  logic [31:0]             chk_addr,
   output logic                    chk_hit,
   output logic                    wr_idle,
   // AXI write-address channel
   output logic [3:0]              awid,
   output logic [31:0]             awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic [1:0]              awlock,
   output logic [3:0]              awcache,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   // AXI write-data channel
   output logic [3:0]              wid,
   output logic [31:0]             wdata,
   output logic [3:0]              wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   // AXI write-response channel
   input  logic [3:0]              bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int OFF_W  = $clog2(D_BYTES_PER_LINE);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = $clog2(D_WORDS_PER_LINE);

   localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(D_WORDS_PER_LINE - 1);
   localparam logic [7:0]        LINE_LEN  = 8'(D_WORDS_PER_LINE - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEND   = 2'd1;
   localparam logic [1:0] S_WAIT_B = 2'd2;

   // entry storage; no reset needed because occupancy is tracked by count
   logic [D_WORDS_PER_LINE-1:0][31:0] q_data  [DEPTH];
   logic [31:0]                       q_addr  [DEPTH];
   logic                              q_burst [DEPTH];
   logic [1:0]                        q_size  [DEPTH];
   logic [3:0]                        q_strb  [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [1:0]        state;
   logic              aw_done;
   logic              w_done;
   logic [BEAT_W-1:0] beat;

   logic push;
   logic pop;
   logic aw_hs;
   logic w_hs;
   logic w_final;
   logic aw_fin;
   logic w_fin;
   logic head_burst;

   assign wr_rdy  = (count != FULL);
   assign push    = wr_req && wr_rdy;
   // retire only once the response arrives; wr_rdy deliberately ignores this
   assign pop     = (state == S_WAIT_B) && bvalid;

   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign w_final = w_hs && wlast;
   assign aw_fin  = aw_done || aw_hs;
   assign w_fin   = w_done || w_final;

   assign head_burst = q_burst[head];

   // capture a new entry at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         q_data[tail]  <= data;
         q_addr[tail]  <= addr;
         q_burst[tail] <= burst;
         q_size[tail]  <= size;
         q_strb[tail]  <= strb;
      end
   end

   // circular pointers and occupancy; power-of-two DEPTH lets the pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // issue engine: AW and W complete independently, then wait for the response
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         beat    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if ((count != '0) && !read_unfinish) begin
                  state   <= S_SEND;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  beat    <= '0;
               end
            end
            S_SEND: begin
               if (aw_hs)          aw_done <= 1'b1;
               if (w_final)        w_done  <= 1'b1;
               if (w_hs && !wlast) beat    <= beat + 1'b1;
               if (aw_fin && w_fin) state  <= S_WAIT_B;
            end
            S_WAIT_B: begin
               if (bvalid) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // read-after-write conflict check over every occupied entry, head included until retired
   always_comb begin
      logic [PTR_W-1:0] offs;
      offs    = '0;
      chk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PTR_W'(i) - head;
         if (({1'b0, offs} < count) &&
             (q_addr[i][31:OFF_W] == chk_addr[31:OFF_W]))
            chk_hit = 1'b1;
      end
   end

   assign wr_idle = (count == '0) && (state == S_IDLE);

   // AW channel: full lines are INCR word bursts, singles are one FIXED beat
   assign awid    = AXI_ID;
   assign awaddr  = q_addr[head];
   assign awlen   = head_burst ? LINE_LEN : 8'd0;
   assign awsize  = head_burst ? 3'd2 : {1'b0, q_size[head]};
   assign awburst = head_burst ? 2'b01 : 2'b00;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;
   assign awvalid = (state == S_SEND) && !aw_done;

   // W channel: beat walks the head line; a single write always sends word 0
   assign wid    = AXI_ID;
   assign wdata  = q_data[head][beat];
   assign wstrb  = head_burst ? 4'hF : q_strb[head];
   assign wlast  = head_burst ? (beat == LAST_BEAT) : 1'b1;
   assign wvalid = (state == S_SEND) && !w_done;

   assign bready = 1'b1;

   // response id/status and the in-line offset of chk_addr carry no information here
   logic unused_bits;
   assign unused_bits = ^{bid, bresp, chk_addr[OFF_W-1:0]};

   // channel payloads must not change while a stalled handshake is pending
   a_aw_hold: assert property (@(posedge clk) disable iff (reset)
      (awvalid && !awready) |=> (awvalid && $stable({awaddr, awlen, awsize, awburst})));
   a_w_hold: assert property (@(posedge clk) disable iff (reset)
      (wvalid && !wready) |=> (wvalid && $stable({wdata, wstrb, wlast})));
   a_count_range: assert property (@(posedge clk) disable iff (reset) (count <= FULL));

endmodule

// File: tb/tb_axi_wr_queue.sv
// Bench for axi_wr_queue: directed writes feed an AW/W scoreboard checked by an independent monitor.
// Latency: expectations are queued at enqueue time; the monitor compares whenever a handshake is presented.
// Backpressure: awready/wready/bvalid are driven by the bench to stall and release the engine.
module tb_axi_wr_queue;

   localparam int DEPTH = 4;
   localparam logic [3:0] ID = 4'd5;

   logic         clk;
   logic         reset;
   logic         wr_req;
   logic         wr_rdy;
   logic         burst;
   logic [127:0] data;
   logic [31:0]  addr;
   logic [1:0]   size;
   logic [3:0]   strb;
   logic         read_unfinish;
   logic [31:0]  chk_addr;
   logic         chk_hit;
   logic         wr_idle;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic [1:0]   awlock;
   logic [3:0]   awcache;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;
   logic [3:0]   wid;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   axi_wr_queue #(.D_BYTES_PER_LINE(16), .DEPTH(DEPTH), .AXI_ID(ID)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_rdy(wr_rdy), .burst(burst), .data(data),
      .addr(addr), .size(size), .strb(strb),
      .read_unfinish(read_unfinish), .chk_addr(chk_addr), .chk_hit(chk_hit), .wr_idle(wr_idle),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [63:0] aw_q[$];
   logic [63:0] w_q[$];

   int   aw_n   = 0;
   int   wl_n   = 0;
   int   b_sent = 0;
   logic b_hold = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // monitor: pops the scoreboard on each AW/W handshake and checks stall stability
   initial begin
      logic        stall_aw;
      logic        stall_w;
      logic [63:0] prev_aw;
      logic [63:0] prev_w;
      logic [63:0] v_aw;
      logic [63:0] v_w;
      stall_aw = 1'b0;
      stall_w  = 1'b0;
      prev_aw  = '0;
      prev_w   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_aw = 1'b0;
            stall_w  = 1'b0;
         end else begin
            v_aw = {15'd0, awid, awaddr, awlen, awsize, awburst};
            v_w  = {23'd0, wid, wdata, wstrb, wlast};
            if (stall_aw) begin
               chk("aw_hold_valid", 64'(awvalid), 64'd1);
               chk("aw_hold_payload", v_aw, prev_aw);
            end
            if (stall_w) begin
               chk("w_hold_valid", 64'(wvalid), 64'd1);
               chk("w_hold_payload", v_w, prev_w);
            end
            if (awvalid && awready) begin
               aw_n++;
               if (aw_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL aw_unexpected: got %h with no write outstanding", v_aw);
               end else begin
                  chk("aw", v_aw, aw_q.pop_front());
               end
            end
            if (wvalid && wready) begin
               if (wlast) wl_n++;
               if (w_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL w_unexpected: got %h with no beat outstanding", v_w);
               end else begin
                  chk("w", v_w, w_q.pop_front());
               end
            end
            stall_aw = awvalid && !awready;
            stall_w  = wvalid && !wready;
            prev_aw  = v_aw;
            prev_w   = v_w;
         end
      end
   end

   // B responder: one response pulse per completed AW+W pair unless held off
   initial begin
      bvalid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bvalid) begin
            bvalid = 1'b0;
         end else if (!b_hold && !reset && (aw_n > b_sent) && (wl_n > b_sent)) begin
            bvalid = 1'b1;
            b_sent++;
         end
      end
   end

   // one enqueue attempt; expected AW/W traffic is queued only if wr_rdy allowed it
   task automatic try_enq(input logic b, input logic [31:0] a, input logic [1:0] sz,
                          input logic [3:0] st, input logic [127:0] d, output logic acc);
      burst  = b;
      addr   = a;
      size   = sz;
      strb   = st;
      data   = d;
      wr_req = 1'b1;
      @(negedge clk);
      acc = wr_rdy;
      if (acc) begin
         aw_q.push_back({15'd0, ID, a, (b ? 8'd3 : 8'd0), (b ? 3'd2 : {1'b0, sz}), (b ? 2'b01 : 2'b00)});
         if (b) begin
            for (int i = 0; i < 4; i++)
               w_q.push_back({23'd0, ID, d[i*32 +: 32], 4'hF, (i == 3)});
         end else begin
            w_q.push_back({23'd0, ID, d[31:0], st, 1'b1});
         end
      end
      @(posedge clk);
      #1;
   endtask

   // enqueue, retrying while the buffer is full
   task automatic enq(input logic b, input logic [31:0] a, input logic [1:0] sz,
                      input logic [3:0] st, input logic [127:0] d);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) try_enq(b, a, sz, st, d, acc);
      wr_req = 1'b0;
      chk("enq_accept", 64'(acc), 64'd1);
   endtask

   // drain: engine idle and every expected handshake seen
   task automatic wait_idle(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = wr_idle && (aw_q.size() == 0) && (w_q.size() == 0);
      end
      chk(name, 64'(ok), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      reset = 1'b1; wr_req = 1'b0; burst = 1'b0; data = '0; addr = '0; size = '0; strb = '0;
      read_unfinish = 1'b0; chk_addr = '0; awready = 1'b1; wready = 1'b1; bid = '0; bresp = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_wr_rdy", 64'(wr_rdy), 64'd1);
      chk("rst_wr_idle", 64'(wr_idle), 64'd1);
      chk("rst_chk_hit", 64'(chk_hit), 64'd0);
      chk("rst_valids", 64'({awvalid, wvalid}), 64'd0);
      chk("rst_bready", 64'(bready), 64'd1);
      chk("rst_tieoffs", 64'({awlock, awcache, awprot}), 64'd0);
      @(posedge clk); #1;

      // full-line burst, all ready
      enq(1'b1, 32'h0000_1000, 2'd0, 4'h0, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);
      wait_idle("burst_drain");
      @(negedge clk);
      chk("burst_idle", 64'(wr_idle), 64'd1);
      @(posedge clk); #1;

      // single halfword write
      enq(1'b0, 32'h0000_2004, 2'd1, 4'hC, 128'h0000_0000_0000_0000_0000_0000_1234_5678);
      wait_idle("single_drain");

      // AW stalled while W completes
      awready = 1'b0;
      enq(1'b1, 32'h0000_3000, 2'd0, 4'h0, 128'h3333_0003_3333_0002_3333_0001_3333_0000);
      repeat (7) @(negedge clk);
      chk("awstall_awvalid", 64'(awvalid), 64'd1);
      chk("awstall_wvalid", 64'(wvalid), 64'd0);
      chk("awstall_awaddr", 64'(awaddr), 64'h3000);
      chk("awstall_not_idle", 64'(wr_idle), 64'd0);
      @(posedge clk); #1;
      awready = 1'b1;
      wait_idle("awstall_drain");

      // fill the buffer with the response held off
      b_hold = 1'b1;
      enq(1'b1, 32'h0000_1000, 2'd0, 4'h0, 128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0);
      enq(1'b0, 32'h0000_4000, 2'd2, 4'hF, 128'h0000_0000_0000_0000_0000_0000_4444_4444);
      enq(1'b0, 32'h0000_5000, 2'd0, 4'h1, 128'h0000_0000_0000_0000_0000_0000_0000_0055);
      enq(1'b0, 32'h0000_6000, 2'd1, 4'h3, 128'h0000_0000_0000_0000_0000_0000_0000_6666);
      @(negedge clk);
      chk("full_wr_rdy", 64'(wr_rdy), 64'd0);
      @(posedge clk); #1;
      try_enq(1'b0, 32'h0000_7000, 2'd2, 4'hF, 128'h7777_7777, acc);
      wr_req = 1'b0;
      chk("full_drop", 64'(acc), 64'd0);
      chk_addr = 32'h0000_100C;
      @(negedge clk);
      chk("hit_head_line", 64'(chk_hit), 64'd1);
      @(posedge clk); #1;
      chk_addr = 32'h0000_2000;
      @(negedge clk);
      chk("miss_line", 64'(chk_hit), 64'd0);
      @(posedge clk); #1;
      chk_addr = 32'h0000_600F;
      @(negedge clk);
      chk("hit_tail_line", 64'(chk_hit), 64'd1);
      @(posedge clk); #1;
      // request stays asserted across the retire cycle; it must enter exactly once
      b_hold = 1'b0;
      enq(1'b0, 32'h0000_7000, 2'd2, 4'hF, 128'h7777_7777);
      wait_idle("full_drain");
      chk_addr = 32'h0000_100C;
      @(negedge clk);
      chk("hit_after_retire", 64'(chk_hit), 64'd0);
      @(posedge clk); #1;

      // wrap-around: more than 2*DEPTH entries back to back, order preserved
      for (int k = 0; k < 2 * DEPTH + 1; k++) begin
         enq(k[0], 32'h0000_A000 + 32'(k) * 32'h40, 2'(k), 4'(k + 1),
             {32'hD000_0003 + 32'(k), 32'hD000_0002 + 32'(k), 32'hD000_0001 + 32'(k), 32'hC000_0000 + 32'(k)});
      end
      wait_idle("wrap_drain");

      // reads in flight hold off issue
      read_unfinish = 1'b1;
      enq(1'b0, 32'h0000_8000, 2'd2, 4'hF, 128'h8888_8888);
      repeat (5) @(negedge clk);
      chk("rd_block_valids", 64'({awvalid, wvalid}), 64'd0);
      chk("rd_block_busy", 64'(wr_idle), 64'd0);
      @(posedge clk); #1;
      read_unfinish = 1'b0;
      wait_idle("rd_block_drain");

      // reset while waiting for the response
      b_hold = 1'b1;
      enq(1'b1, 32'h0000_9000, 2'd0, 4'h0, 128'h9999_0003_9999_0002_9999_0001_9999_0000);
      repeat (8) @(negedge clk);
      chk("waitb_busy", 64'(wr_idle), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_addr = 32'h0000_9000;
      @(negedge clk);
      chk("waitb_rst_idle", 64'(wr_idle), 64'd1);
      chk("waitb_rst_rdy", 64'(wr_rdy), 64'd1);
      chk("waitb_rst_hit", 64'(chk_hit), 64'd0);
      chk("waitb_rst_valids", 64'({awvalid, wvalid}), 64'd0);
      @(posedge clk); #1;
      b_sent = aw_n;
      b_hold = 1'b0;

      // normal operation after the abandoned transaction
      enq(1'b0, 32'h0000_B008, 2'd2, 4'h5, 128'hBBBB_0008);
      wait_idle("post_rst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
